// File: rtl/vm_pkg.sv
// Shared definitions for the vending machine controller: coin codes, coin values and FSM states.
package vm_pkg;

  localparam int ITEMS     = 9;
  localparam int NUM_COINS = 6;

  typedef enum logic [2:0] {
    NICKEL  = 3'd0,
    DIME    = 3'd1,
    QUARTER = 3'd2,
    FIFTY   = 3'd3,
    DOLLAR  = 3'd4,
    FIVE    = 3'd5
  } coin_t;

  localparam int DENOM_CENTS [NUM_COINS] = '{5, 10, 25, 50, 100, 500};

  typedef enum logic [1:0] {
    IDLE,
    SHOW_PRICE,
    VEND,
    CHANGE
  } state_t;

  // Codes 6 and 7 are unused and carry no value.
  function automatic int denom_cents(input logic [2:0] code);
    if (code > 3'd5) return 0;
    return DENOM_CENTS[code];
  endfunction

endpackage

// File: rtl/change_picker.sv
// Greedy change selection: the largest coin not exceeding the remaining credit.
module change_picker
  import vm_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic [CW-1:0] credit,
  output logic [2:0]    coin,
  output logic [CW-1:0] denom,
  output logic          valid
);

  // Ascending scan so the largest fitting denomination is the one left standing.
  always_comb begin
    coin  = 3'd0;
    denom = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (credit >= CW'(DENOM_CENTS[i])) begin
        coin  = 3'(i);
        denom = CW'(DENOM_CENTS[i]);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencer: coin credit, price display, selection checks, vend strobe and
// one-coin-at-a-time change payout over a valid/ready handshake.
module vend_controller
  import vm_pkg::*;
#(
  parameter int CW         = 12,
  parameter int MAX_CREDIT = 995,
  parameter int PRICE_HOLD = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        coin_in,
  input  logic [8:0]        sel_in,
  input  logic              cancel,
  input  logic [9*CW-1:0]   price_flat,
  input  logic [8:0]        in_stock,
  output logic [8:0]        afford,
  output logic [8:0]        oos,
  output logic [CW-1:0]     disp_val,
  output logic              coin_reject,
  output logic              vend,
  output logic [3:0]        vend_sel,
  output logic              chg_valid,
  output logic [2:0]        chg_coin,
  input  logic              chg_ready,
  output logic              busy
);

  localparam int HW = $clog2(PRICE_HOLD + 1);

  state_t          state;
  logic [CW-1:0]   credit;
  logic [CW-1:0]   held_price;
  logic [HW-1:0]   hold_cnt;

  logic [CW-1:0]   price [ITEMS];
  logic            coin_any;
  logic [2:0]      coin_code;
  logic [CW:0]     coin_sum;
  logic            coin_ok;
  logic            sel_any;
  logic [3:0]      sel_idx;
  logic [CW-1:0]   remainder;
  logic [2:0]      pick_coin;
  logic [CW-1:0]   pick_denom;
  logic            pick_valid;

  always_comb begin
    for (int i = 0; i < ITEMS; i++) begin
      price[i]  = price_flat[i*CW +: CW];
      afford[i] = in_stock[i] && (credit >= price[i]);
    end
  end

  // Multi-hot pulses resolve to the lowest set bit, hence the descending scans.
  always_comb begin
    coin_code = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (coin_in[i]) coin_code = 3'(i);
    end
    sel_idx = 4'd0;
    for (int i = ITEMS - 1; i >= 0; i--) begin
      if (sel_in[i]) sel_idx = 4'(i);
    end
  end

  assign coin_any  = |coin_in;
  assign sel_any   = |sel_in;
  assign coin_sum  = {1'b0, credit} + (CW+1)'(denom_cents(coin_code));
  assign coin_ok   = coin_sum <= (CW+1)'(MAX_CREDIT);
  assign remainder = credit - price[vend_sel];

  change_picker #(.CW(CW)) u_picker (
    .credit (credit),
    .coin   (pick_coin),
    .denom  (pick_denom),
    .valid  (pick_valid)
  );

  assign oos       = ~in_stock;
  assign busy      = (state == VEND) || (state == CHANGE);
  assign chg_valid = (state == CHANGE) && pick_valid;
  assign chg_coin  = pick_coin;
  assign disp_val  = (state == SHOW_PRICE) ? held_price : credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      held_price  <= '0;
      hold_cnt    <= '0;
      vend        <= 1'b0;
      vend_sel    <= 4'd0;
      coin_reject <= 1'b0;
    end else begin
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          // A coin arriving alongside an accepted cancel/selection is handed back, never swallowed.
          if (cancel && credit != '0) begin
            state       <= CHANGE;
            coin_reject <= coin_any;
          end else if (sel_any && credit == '0) begin
            state       <= SHOW_PRICE;
            held_price  <= price[sel_idx];
            hold_cnt    <= HW'(PRICE_HOLD);
            coin_reject <= coin_any;
          end else if (sel_any && afford[sel_idx]) begin
            state       <= VEND;
            vend        <= 1'b1;
            vend_sel    <= sel_idx;
            coin_reject <= coin_any;
          end else if (coin_any) begin
            if (coin_ok) credit <= coin_sum[CW-1:0];
            else         coin_reject <= 1'b1;
          end
        end

        SHOW_PRICE: begin
          if (sel_any) begin
            held_price  <= price[sel_idx];
            hold_cnt    <= HW'(PRICE_HOLD);
            coin_reject <= coin_any;
          end else if (coin_any) begin
            state <= IDLE;
            if (coin_ok) credit <= coin_sum[CW-1:0];
            else         coin_reject <= 1'b1;
          end else if (hold_cnt <= HW'(1)) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end

        VEND: begin
          coin_reject <= coin_any;
          credit      <= remainder;
          state       <= (remainder != '0) ? CHANGE : IDLE;
        end

        CHANGE: begin
          coin_reject <= coin_any;
          // A sub-nickel residue cannot be paid out and is dropped.
          if (!pick_valid) begin
            credit <= '0;
            state  <= IDLE;
          end else if (chg_ready) begin
            credit <= credit - pick_denom;
            if (credit == pick_denom) state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: credit, price hold, vend, change payout, rejects and reset.
module tb_vend_controller;
  import vm_pkg::*;

  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      coin_in;
  logic [8:0]      sel_in;
  logic            cancel;
  logic [9*CW-1:0] price_flat;
  logic [8:0]      in_stock;
  logic [8:0]      afford;
  logic [8:0]      oos;
  logic [CW-1:0]   disp_val;
  logic            coin_reject;
  logic            vend;
  logic [3:0]      vend_sel;
  logic            chg_valid;
  logic [2:0]      chg_coin;
  logic            chg_ready;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  vend_controller #(.CW(CW), .MAX_CREDIT(995), .PRICE_HOLD(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_in     (coin_in),
    .sel_in      (sel_in),
    .cancel      (cancel),
    .price_flat  (price_flat),
    .in_stock    (in_stock),
    .afford      (afford),
    .oos         (oos),
    .disp_val    (disp_val),
    .coin_reject (coin_reject),
    .vend        (vend),
    .vend_sel    (vend_sel),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .chg_ready   (chg_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of pulses at the falling edge; returns 1ns after the capturing edge.
  task automatic applyStimulus(input logic [5:0] c, input logic [8:0] s, input logic x);
    @(negedge clk);
    coin_in = c;
    sel_in  = s;
    cancel  = x;
    @(posedge clk);
    #1;
    coin_in = '0;
    sel_in  = '0;
    cancel  = 1'b0;
  endtask

  task automatic collectChange(input int n, input int codes[8], input int rems[8],
                               input int stall_at, input int stall_len);
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 50 && !chg_valid; w++) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("chg_valid[%0d]", k), int'(chg_valid), 1);
      checkOutput($sformatf("chg_coin[%0d]", k), int'(chg_coin), codes[k]);
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk);
          #1;
          checkOutput($sformatf("stall_coin[%0d]", s), int'(chg_coin), codes[k]);
        end
      end
      chg_ready = 1'b1;
      @(posedge clk);
      #1;
      chg_ready = 1'b0;
      checkOutput($sformatf("chg_rem[%0d]", k), int'(disp_val), rems[k]);
    end
    checkOutput("chg_done_valid", int'(chg_valid), 0);
    checkOutput("chg_done_busy", int'(busy), 0);
  endtask

  int prices [9] = '{75, 100, 10, 200, 130, 300, 500, 995, 135};
  int codes [8];
  int rems [8];
  int hold_cycles;
  int vend_seen;

  initial begin
    for (int i = 0; i < 9; i++) price_flat[i*CW +: CW] = CW'(prices[i]);
    in_stock  = 9'b111111011;
    coin_in   = '0;
    sel_in    = '0;
    cancel    = 1'b0;
    chg_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_disp", int'(disp_val), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_chg_valid", int'(chg_valid), 0);
    checkOutput("rst_afford", int'(afford), 0);
    checkOutput("rst_oos", int'(oos), 9'b000000100);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] quarters then A1");
    repeat (4) applyStimulus(6'b000100, 9'd0, 1'b0);
    checkOutput("q4_credit", int'(disp_val), 100);
    checkOutput("q4_afford", int'(afford), 9'b000000011);
    applyStimulus(6'd0, 9'b000000001, 1'b0);
    checkOutput("a1_vend", int'(vend), 1);
    checkOutput("a1_vend_sel", int'(vend_sel), 0);
    checkOutput("a1_busy", int'(busy), 1);
    codes[0] = QUARTER; rems[0] = 0;
    collectChange(1, codes, rems, -1, 0);

    $display("[TB] price hold B2");
    applyStimulus(6'd0, 9'b000010000, 1'b0);
    hold_cycles = 0;
    vend_seen   = 0;
    for (int i = 0; i < 300 && disp_val == 12'd130; i++) begin
      hold_cycles++;
      if (vend) vend_seen = 1;
      @(posedge clk);
      #1;
    end
    checkOutput("hold_cycles", hold_cycles, 200);
    checkOutput("hold_after", int'(disp_val), 0);
    checkOutput("hold_no_vend", vend_seen, 0);

    $display("[TB] five+dollar then C3 with stalled payout");
    applyStimulus(6'b100000, 9'd0, 1'b0);
    applyStimulus(6'b010000, 9'd0, 1'b0);
    checkOutput("c3_credit", int'(disp_val), 600);
    applyStimulus(6'd0, 9'b100000000, 1'b0);
    checkOutput("c3_vend", int'(vend), 1);
    checkOutput("c3_vend_sel", int'(vend_sel), 8);
    codes = '{DOLLAR, DOLLAR, DOLLAR, DOLLAR, FIFTY, DIME, NICKEL, 0};
    rems  = '{365, 265, 165, 65, 15, 5, 0, 0};
    collectChange(7, codes, rems, 1, 3);

    $display("[TB] credit ceiling and busy rejects");
    applyStimulus(6'b100000, 9'd0, 1'b0);
    repeat (4) applyStimulus(6'b010000, 9'd0, 1'b0);
    applyStimulus(6'b001000, 9'd0, 1'b0);
    checkOutput("ceil_credit", int'(disp_val), 950);
    applyStimulus(6'b010000, 9'd0, 1'b0);
    checkOutput("ceil_reject", int'(coin_reject), 1);
    checkOutput("ceil_hold", int'(disp_val), 950);
    applyStimulus(6'b000100, 9'd0, 1'b1);
    checkOutput("cancel_coin_reject", int'(coin_reject), 1);
    checkOutput("cancel_busy", int'(busy), 1);
    applyStimulus(6'b000100, 9'd0, 1'b0);
    checkOutput("busy_reject", int'(coin_reject), 1);
    checkOutput("busy_credit", int'(disp_val), 950);
    codes = '{FIVE, DOLLAR, DOLLAR, DOLLAR, DOLLAR, FIFTY, 0, 0};
    rems  = '{450, 350, 250, 150, 50, 0, 0, 0};
    collectChange(6, codes, rems, -1, 0);

    $display("[TB] out-of-stock A3 then cancel");
    applyStimulus(6'b000010, 9'd0, 1'b0);
    applyStimulus(6'b000001, 9'd0, 1'b0);
    checkOutput("oos_credit", int'(disp_val), 15);
    checkOutput("oos_afford2", int'(afford[2]), 0);
    checkOutput("oos_led2", int'(oos[2]), 1);
    applyStimulus(6'd0, 9'b000000100, 1'b0);
    checkOutput("oos_no_vend", int'(vend), 0);
    checkOutput("oos_not_busy", int'(busy), 0);
    applyStimulus(6'd0, 9'd0, 1'b1);
    codes = '{DIME, NICKEL, 0, 0, 0, 0, 0, 0};
    rems  = '{5, 0, 0, 0, 0, 0, 0, 0};
    collectChange(2, codes, rems, -1, 0);

    $display("[TB] reset during payout");
    applyStimulus(6'b010000, 9'd0, 1'b0);
    applyStimulus(6'd0, 9'd0, 1'b1);
    checkOutput("mid_chg_valid", int'(chg_valid), 1);
    checkOutput("mid_chg_coin", int'(chg_coin), DOLLAR);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_credit", int'(disp_val), 0);
    checkOutput("rst_mid_valid", int'(chg_valid), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);

    $display("[TB] multi-hot coin resolves to lowest");
    applyStimulus(6'b000110, 9'd0, 1'b0);
    checkOutput("multihot_credit", int'(disp_val), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
